// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - fetch PC owner, in-order imem requester and prefetch FIFO
//
// Purpose: owns the fetch PC, keeps the instruction memory busy with in-order
// requests, buffers returned words in a small FIFO and presents the head entry
// to the IF/ID register. Redirects from Execute/Writeback flush the FIFO and
// discard responses that are still in flight.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   stallF                         1 = hold the head entry (no pop)
//   BranchTakenE, BranchTargetE    Execute-stage redirect and target
//   PCSrcW, ResultW                Writeback-stage redirect and target (wins)
//   imem_req, imem_addr, imem_gnt  request handshake, word-aligned address
//   imem_rvalid, imem_rdata        in-order response
//   InstrF, PCF, ValidF            head entry (zero when ValidF=0)
//   redirect_drop                  pulses when a response is discarded
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic        ValidF,
  output logic        redirect_drop
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];

  logic        redirect;
  logic [31:0] redirect_target;
  logic        issue_ok;
  logic        grant;
  logic        push;
  logic        discard;
  logic        pop;

  // Writeback is the older instruction, so its PC write wins over Execute.
  assign redirect        = PCSrcW | BranchTakenE;
  assign redirect_target = PCSrcW ? ResultW : BranchTargetE;

  // Never issue more than the FIFO can absorb: buffered plus in-flight words
  // are bounded by DEPTH, which is what makes overflow impossible.
  assign issue_ok = ({1'b0, count_q} + {1'b0, outstanding_q}) < {1'b0, DEPTH_C};

  // Gated by reset so the request drops the instant reset asserts.
  assign imem_req  = !reset && !redirect && issue_ok;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  // A response arriving in a redirect cycle belongs to the old path.
  assign push    = imem_rvalid && (drop_cnt_q == '0) && !redirect;
  assign discard = imem_rvalid && ((drop_cnt_q != '0) || redirect);

  assign ValidF = (count_q != '0);
  assign pop    = ValidF && !stallF && !redirect;

  assign InstrF        = ValidF ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign PCF           = ValidF ? pc_mem_q[rd_ptr_q]    : 32'h0;
  assign redirect_drop = discard && !reset;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    instr_mem_d   = instr_mem_q;
    pc_mem_d      = pc_mem_q;
    // Every response retires one outstanding request, kept or discarded.
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);

    if (redirect) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Everything still in flight is old-path; outstanding already includes
      // any drops left over from an earlier redirect.
      drop_cnt_d = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        instr_mem_d[wr_ptr_q] = imem_rdata;
        pc_mem_d[wr_ptr_q]    = resp_pc_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        // Responses are in order, so the PC of the next kept word is +4.
        resp_pc_d             = resp_pc_q + 32'd4;
      end
      if (discard) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      instr_mem_q   <= '{default: '0};
      pc_mem_q      <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      instr_mem_q   <= instr_mem_d;
      pc_mem_q      <= pc_mem_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == DEPTH_C)));

  a_occupancy: assert property (@(posedge clk) disable iff (reset)
    (({1'b0, count_q} + {1'b0, outstanding_q}) <= {1'b0, DEPTH_C}));

  a_rvalid_expected: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb/tb_fetch_prefetch_buffer.sv - scoreboard bench for fetch_prefetch_buffer
module tb_fetch_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          SEG_LEN  = 80;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF;
  logic        BranchTakenE;
  logic [31:0] BranchTargetE;
  logic        PCSrcW;
  logic [31:0] ResultW;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        ValidF;
  logic        redirect_drop;

  fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .stallF(stallF),
    .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
    .PCSrcW(PCSrcW), .ResultW(ResultW),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .PCF(PCF), .ValidF(ValidF), .redirect_drop(redirect_drop)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Expected head PCs, in delivery order, for the current fetch path.
  logic [31:0] exp_q[$];

  task automatic new_segment(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < SEG_LEN; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Memory model: in-order, per-request latency chosen at grant time.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  int          cyc        = 0;
  int          lat        = 1;
  logic        watch_100  = 1'b0;
  int          bad_fetch  = 0;
  logic        grab_first = 1'b0;
  int          first_seen = 0;
  logic [31:0] first_addr = 32'hFFFF_FFFF;
  int          pulse_cnt  = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend_q.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end else begin
        if (imem_req && imem_gnt) begin
          pend_q.push_back('{addr: imem_addr, due: cyc + 1 + lat});
          if (watch_100 && imem_addr == 32'h100) bad_fetch++;
          if (grab_first) begin
            first_addr = imem_addr;
            first_seen = 1;
            grab_first = 1'b0;
          end
        end
        check1("occupancy bound", pend_q.size() <= DEPTH, 1'b1);
        if (pend_q.size() != 0 && pend_q[0].due <= cyc + 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pend_q[0].addr | 32'hE000_0000;
          void'(pend_q.pop_front());
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = 32'h0;
        end
      end
    end
  end

  // Monitor: compares the presented head against the scoreboard.
  initial forever begin
    @(negedge clk);
    #2;
    if (redirect_drop) pulse_cnt++;
    if (!reset && !BranchTakenE && !PCSrcW) begin
      if (ValidF) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL head: got PCF 0x%08h, expected no valid entry", PCF);
        end else begin
          check("head PCF", PCF, exp_q[0]);
          check("head InstrF", InstrF, exp_q[0] | 32'hE000_0000);
          if (!stallF) void'(exp_q.pop_front());
        end
      end else begin
        check("idle PCF", PCF, 32'h0);
        check("idle InstrF", InstrF, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    stallF        = 1'b0;
    BranchTakenE  = 1'b0;
    BranchTargetE = 32'h0;
    PCSrcW        = 1'b0;
    ResultW       = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check1("reset imem_req", imem_req, 1'b0);
    check1("reset ValidF", ValidF, 1'b0);
    check("reset InstrF", InstrF, 32'h0);
    check("reset PCF", PCF, 32'h0);
    check1("reset redirect_drop", redirect_drop, 1'b0);
    check("reset imem_addr", imem_addr, RESET_PC);
    new_segment(RESET_PC);

    // Stream with 1-cycle memory: two-cycle fill then one PC per cycle
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check1("first imem_req", imem_req, 1'b1);
    check("first imem_addr", imem_addr, RESET_PC);
    @(posedge clk); #2;
    check1("fill ValidF cycle1", ValidF, 1'b0);
    @(posedge clk); #2;
    check1("fill ValidF cycle2", ValidF, 1'b1);
    check("fill PCF", PCF, 32'h0);
    check("fill InstrF", InstrF, 32'hE000_0000);
    repeat (15) @(posedge clk);
    #1;

    // Stall fill: head frozen, requests stop once the FIFO is full
    @(posedge clk); #1 stallF = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (i >= 3) check1("stall imem_req", imem_req, 1'b0);
      check1("stall ValidF", ValidF, 1'b1);
      @(posedge clk); #1;
    end
    stallF = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #2;
      check1("release ValidF", ValidF, 1'b1);
      @(posedge clk); #1;
    end

    // Branch with 3 in flight, one of them returning in the redirect cycle
    lat = 3;
    PCSrcW = 1'b1; ResultW = 32'h80;
    new_segment(32'h80);
    @(posedge clk); #1 PCSrcW = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    BranchTakenE = 1'b1; BranchTargetE = 32'h100;
    pulse_cnt = 0;
    new_segment(32'h100);
    @(posedge clk); #1 BranchTakenE = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("branch drop pulses", 32'(pulse_cnt), 32'd3);
    check1("branch path delivered", exp_q.size() < SEG_LEN, 1'b1);

    // Simultaneous redirect: Writeback target wins
    PCSrcW = 1'b1; ResultW = 32'h200;
    BranchTakenE = 1'b1; BranchTargetE = 32'h100;
    new_segment(32'h200);
    watch_100 = 1'b1;
    @(posedge clk); #1 PCSrcW = 1'b0; BranchTakenE = 1'b0;
    #1;
    check("simul redirect addr", imem_addr, 32'h200);
    check1("simul redirect req", imem_req, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    check("no fetch of 0x100", 32'(bad_fetch), 32'd0);
    check1("simul path delivered", exp_q.size() < SEG_LEN, 1'b1);

    // Drain, then build count=3 outstanding=1 on a fresh 1-cycle path
    stallF = 1'b1; lat = 1;
    repeat (20) begin @(posedge clk); #1; end
    stallF = 1'b0; BranchTakenE = 1'b1; BranchTargetE = 32'h300;
    new_segment(32'h300);
    @(posedge clk); #1 BranchTakenE = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 stallF = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    check1("pre-reset ValidF", ValidF, 1'b1);
    check("pre-reset PCF", PCF, 32'h300);
    check1("pre-reset imem_req", imem_req, 1'b0);

    // Async reset between edges
    #1 reset = 1'b1;
    new_segment(RESET_PC);
    #1;
    check1("async reset ValidF", ValidF, 1'b0);
    check1("async reset imem_req", imem_req, 1'b0);
    check("async reset PCF", PCF, 32'h0);
    check("async reset InstrF", InstrF, 32'h0);
    check1("async reset redirect_drop", redirect_drop, 1'b0);
    @(posedge clk); #1 stallF = 1'b0;
    @(posedge clk); #1 reset = 1'b0; grab_first = 1'b1;
    #1;
    check1("post-reset imem_req", imem_req, 1'b1);
    check("post-reset imem_addr", imem_addr, RESET_PC);
    repeat (10) @(posedge clk);
    #1;
    check("post-reset grant seen", 32'(first_seen), 32'd1);
    check("post-reset first grant", first_addr, RESET_PC);
    check1("post-reset path delivered", exp_q.size() < SEG_LEN, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
